// File: rtl/jp_io_exec_sequencer_pkg.sv
// Shared types and constants for the Z80 execution-side sequencers.
// Used by the JP/IN/OUT sequencer and its condition evaluator.
package z80_exec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_LO,
        S_FETCH_HI,
        S_FETCH_N,
        S_IO_RD,
        S_IO_WR,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        OP_JPNN,
        OP_JPCC,
        OP_IN,
        OP_OUT
    } op_t;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_PV = 2;
    localparam int FLAG_C  = 0;

    localparam logic [2:0] CC_NZ = 3'd0;
    localparam logic [2:0] CC_Z  = 3'd1;
    localparam logic [2:0] CC_NC = 3'd2;
    localparam logic [2:0] CC_C  = 3'd3;
    localparam logic [2:0] CC_PO = 3'd4;
    localparam logic [2:0] CC_PE = 3'd5;
    localparam logic [2:0] CC_P  = 3'd6;
    localparam logic [2:0] CC_M  = 3'd7;

    // cc[2:1] picks the flag under test
    localparam logic [1:0] CCSEL_Z  = 2'd0;
    localparam logic [1:0] CCSEL_C  = 2'd1;
    localparam logic [1:0] CCSEL_PV = 2'd2;
    localparam logic [1:0] CCSEL_S  = 2'd3;

    function automatic logic [2:0] onehot8_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/jp_io_exec_sequencer_if.sv
// Memory-read and I/O bus seen by the JP/IN/OUT sequencer.
// master = sequencer side, slave = memory / port side.
interface jp_io_exec_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              io_rd_req;
    logic              io_wr_req;
    logic [ADDR_W-1:0] io_addr;
    logic [7:0]        io_wdata;
    logic              io_ack;
    logic [7:0]        io_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output io_rd_req,
        output io_wr_req,
        output io_addr,
        output io_wdata,
        input  io_ack,
        input  io_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  io_rd_req,
        input  io_wr_req,
        input  io_addr,
        input  io_wdata,
        output io_ack,
        output io_rdata
    );
endinterface

// File: rtl/jp_io_exec_sequencer_cc_eval.sv
// Z80 condition-code evaluator, shared by the JP/JR/CALL/RET cc executors.
// cc[2:1] selects Z/C/PV/S, cc[0] selects the polarity that means "taken".
module cc_eval
    import z80_exec_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [7:0] flags,
    output logic       taken
);

    logic w_flag;
    logic w_unused_flags;

    assign w_unused_flags = ^{flags[5:3], flags[1]};

    always_comb begin
        w_flag = 1'b0;
        unique case (cc[2:1])
            CCSEL_Z:  w_flag = flags[FLAG_Z];
            CCSEL_C:  w_flag = flags[FLAG_C];
            CCSEL_PV: w_flag = flags[FLAG_PV];
            CCSEL_S:  w_flag = flags[FLAG_S];
        endcase
    end

    assign taken = ~(w_flag ^ cc[0]);

endmodule

// File: rtl/jp_io_exec_sequencer.sv
// Executes JP nn, JP cc,nn, IN A,(n) and OUT (n),A: operand fetch,
// condition evaluation, I/O bus cycle, then PC/A commit.
module jp_io_exec_sequencer
    import z80_exec_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              notRESET,
    input  logic              set_jpnn,
    input  logic [7:0]        set_jpcc,
    input  logic              set_out,
    input  logic              set_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        a_in,
    input  logic [7:0]        flags_in,
    jp_io_exec_sequencer_if.master bus,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_value,
    output logic              a_load,
    output logic [7:0]        a_value,
    output logic              busy,
    output logic              err
);

    state_t            r_state;
    op_t               r_op;
    logic [2:0]        r_cc;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_a;
    logic [7:0]        r_flags;
    logic [7:0]        r_lo;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_io_rd_req;
    logic              r_io_wr_req;
    logic [ADDR_W-1:0] r_io_addr;
    logic [7:0]        r_io_wdata;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_pc_value;
    logic              r_a_load;
    logic [7:0]        r_a_value;
    logic              r_busy;
    logic              r_err;

    logic [10:0]       w_strobes;
    logic              w_any;
    logic              w_one;
    logic              w_multi;
    op_t               w_op;
    logic              w_is_io;
    logic              w_cc_taken;
    logic              w_jump;

    assign w_strobes = {set_in, set_out, set_jpcc, set_jpnn};
    assign w_any     = |w_strobes;
    assign w_one     = w_any && ((w_strobes & (w_strobes - 11'd1)) == 11'd0);
    assign w_multi   = w_any && !w_one;

    always_comb begin
        w_op = OP_JPCC;
        priority case (1'b1)
            set_jpnn: w_op = OP_JPNN;
            set_in:   w_op = OP_IN;
            set_out:  w_op = OP_OUT;
            default:  w_op = OP_JPCC;
        endcase
    end

    assign w_is_io = (w_op == OP_IN) || (w_op == OP_OUT);

    cc_eval u_cc_eval (
        .cc    (r_cc),
        .flags (r_flags),
        .taken (w_cc_taken)
    );

    assign w_jump = (r_op == OP_JPNN) || w_cc_taken;

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            r_state     <= S_IDLE;
            r_op        <= OP_JPNN;
            r_cc        <= 3'd0;
            r_pc        <= '0;
            r_a         <= 8'd0;
            r_flags     <= 8'd0;
            r_lo        <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_io_rd_req <= 1'b0;
            r_io_wr_req <= 1'b0;
            r_io_addr   <= '0;
            r_io_wdata  <= 8'd0;
            r_pc_load   <= 1'b0;
            r_pc_value  <= '0;
            r_a_load    <= 1'b0;
            r_a_value   <= 8'd0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pc_load <= 1'b0;
            r_a_load  <= 1'b0;
            r_err     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_err <= w_multi;
                    if (w_one) begin
                        r_op       <= w_op;
                        r_cc       <= onehot8_idx(set_jpcc);
                        r_pc       <= pc_in;
                        r_a        <= a_in;
                        r_flags    <= flags_in;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= pc_in;
                        r_state    <= w_is_io ? S_FETCH_N : S_FETCH_LO;
                    end
                end
                S_FETCH_LO: begin
                    // request stays high straight into the high-byte fetch
                    if (bus.mem_ack) begin
                        r_lo       <= bus.mem_rdata;
                        r_mem_addr <= r_pc + ADDR_W'(1);
                        r_state    <= S_FETCH_HI;
                    end
                end
                S_FETCH_HI: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_pc_load <= 1'b1;
                        r_pc_value <= w_jump
                            ? ADDR_W'({bus.mem_rdata, r_lo})
                            : r_pc + ADDR_W'(2);
                        r_state   <= S_COMMIT;
                    end
                end
                S_FETCH_N: begin
                    if (bus.mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_io_addr  <= ADDR_W'({r_a, bus.mem_rdata});
                        r_io_wdata <= r_a;
                        if (r_op == OP_IN) begin
                            r_io_rd_req <= 1'b1;
                            r_state     <= S_IO_RD;
                        end else begin
                            r_io_wr_req <= 1'b1;
                            r_state     <= S_IO_WR;
                        end
                    end
                end
                S_IO_RD: begin
                    if (bus.io_ack) begin
                        r_io_rd_req <= 1'b0;
                        r_a_load    <= 1'b1;
                        r_a_value   <= bus.io_rdata;
                        r_pc_load   <= 1'b1;
                        r_pc_value  <= r_pc + ADDR_W'(1);
                        r_state     <= S_COMMIT;
                    end
                end
                S_IO_WR: begin
                    if (bus.io_ack) begin
                        r_io_wr_req <= 1'b0;
                        r_pc_load   <= 1'b1;
                        r_pc_value  <= r_pc + ADDR_W'(1);
                        r_state     <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.io_rd_req = r_io_rd_req;
    assign bus.io_wr_req = r_io_wr_req;
    assign bus.io_addr   = r_io_addr;
    assign bus.io_wdata  = r_io_wdata;

    assign pc_load  = r_pc_load;
    assign pc_value = r_pc_value;
    assign a_load   = r_a_load;
    assign a_value  = r_a_value;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_jp_io_exec_sequencer.sv
// Directed bench for jp_io_exec_sequencer with a transaction-level model
// and a per-cycle compare process.
module tb_jp_io_exec_sequencer;
    import z80_exec_pkg::*;

    typedef struct {
        logic [15:0] pc;
        bit          aload;
        logic [7:0]  aval;
    } commit_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } io_t;

    logic        CLK = 1'b0;
    logic        notRESET;
    logic        set_jpnn;
    logic [7:0]  set_jpcc;
    logic        set_out;
    logic        set_in;
    logic [15:0] pc_in;
    logic [7:0]  a_in;
    logic [7:0]  flags_in;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        a_load;
    logic [7:0]  a_value;
    logic        busy;
    logic        err;

    jp_io_exec_sequencer_if #(.ADDR_W(16)) bus ();

    jp_io_exec_sequencer #(.ADDR_W(16)) dut (
        .CLK      (CLK),
        .notRESET (notRESET),
        .set_jpnn (set_jpnn),
        .set_jpcc (set_jpcc),
        .set_out  (set_out),
        .set_in   (set_in),
        .pc_in    (pc_in),
        .a_in     (a_in),
        .flags_in (flags_in),
        .bus      (bus),
        .pc_load  (pc_load),
        .pc_value (pc_value),
        .a_load   (a_load),
        .a_value  (a_value),
        .busy     (busy),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    int exp_err_cyc = -1;
    int pc_loads = 0;
    int io_rd_cycles = 0;
    logic [15:0] last_io_addr;
    logic [7:0]  last_io_wdata;

    logic [7:0] mem [0:65535];
    logic [7:0] io_val = 8'h00;
    int  mem_dly = 0;
    int  io_dly = 0;
    bit  resp_en = 1'b1;
    bit  man_mem_ack = 1'b0;
    int  mcnt = 0;
    int  icnt = 0;

    logic [15:0] q_mem[$];
    io_t         q_io[$];
    commit_t     q_cm[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none t=%0t", name, $time);
    endtask

    always @(posedge CLK) cyc++;

    // Memory / port responder: ack after mem_dly / io_dly waiting cycles
    always @(posedge CLK) begin
        #2;
        if (!resp_en) begin
            bus.mem_ack   = man_mem_ack;
            bus.mem_rdata = 8'hEE;
            bus.io_ack    = 1'b0;
            bus.io_rdata  = 8'h00;
            mcnt = 0;
            icnt = 0;
        end else begin
            if (bus.mem_req !== 1'b1) begin
                mcnt = 0;
                bus.mem_ack = 1'b0;
            end else begin
                if (bus.mem_ack === 1'b1) mcnt = 0;
                bus.mem_ack = (mcnt == mem_dly);
                mcnt++;
            end
            bus.mem_rdata = bus.mem_ack ? mem[bus.mem_addr] : 8'h00;
            if ((bus.io_rd_req | bus.io_wr_req) !== 1'b1) begin
                icnt = 0;
                bus.io_ack = 1'b0;
            end else begin
                if (bus.io_ack === 1'b1) icnt = 0;
                bus.io_ack = (icnt == io_dly);
                icnt++;
            end
            bus.io_rdata = bus.io_ack ? io_val : 8'h00;
        end
    end

    function automatic bit cond_true(input int cc, input logic [7:0] f);
        case (cc)
            0: return !f[6];
            1: return f[6];
            2: return !f[0];
            3: return f[0];
            4: return !f[2];
            5: return f[2];
            6: return !f[7];
            default: return f[7];
        endcase
    endfunction

    // kind: 0 JP nn, 1 JP cc,nn, 2 IN, 3 OUT
    task automatic model_push(input int kind, input int cc,
                              input logic [15:0] pc, input logic [7:0] a,
                              input logic [7:0] f);
        commit_t cm;
        io_t     io;
        logic [15:0] pc1;
        logic [15:0] pc2;
        pc1 = pc + 16'd1;
        pc2 = pc + 16'd2;
        q_mem.push_back(pc);
        cm.aload = 1'b0;
        cm.aval  = 8'h00;
        if (kind < 2) begin
            q_mem.push_back(pc1);
            if (kind == 0 || cond_true(cc, f)) cm.pc = {mem[pc1], mem[pc]};
            else cm.pc = pc2;
        end else begin
            io.wr    = (kind == 3);
            io.addr  = {a, mem[pc]};
            io.wdata = a;
            q_io.push_back(io);
            cm.pc = pc1;
            if (kind == 2) begin
                cm.aload = 1'b1;
                cm.aval  = io_val;
            end
        end
        q_cm.push_back(cm);
    endtask

    task automatic issue(input int kind, input int cc, input logic [15:0] pc,
                         input logic [7:0] a, input logic [7:0] f,
                         output logic busy_at_drive);
        model_push(kind, cc, pc, a, f);
        @(posedge CLK);
        #1;
        busy_at_drive = busy;
        pc_in = pc;
        a_in = a;
        flags_in = f;
        case (kind)
            0: set_jpnn = 1'b1;
            1: set_jpcc = 8'(1 << cc);
            2: set_in = 1'b1;
            default: set_out = 1'b1;
        endcase
        c0 = cyc;
        @(posedge CLK);
        #1;
        set_jpnn = 1'b0;
        set_jpcc = 8'h00;
        set_in = 1'b0;
        set_out = 1'b0;
    endtask

    task automatic wait_pc_load(input int budget, output int lat,
                                output logic [15:0] pcv, output logic al,
                                output logic [7:0] av);
        lat = -1;
        pcv = 16'h0;
        al = 1'b0;
        av = 8'h0;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (pc_load === 1'b1) begin
                lat = cyc - c0;
                pcv = pc_value;
                al = a_load;
                av = a_value;
                break;
            end
        end
        if (lat < 0) fail_now("pc_load_timeout");
    endtask

    // Per-cycle comparison against the model queues
    always @(negedge CLK) begin
        if (notRESET === 1'b1) begin
            commit_t cm;
            io_t     io;
            chk("err_pulse", err, (cyc == exp_err_cyc));
            chk("req_needs_busy",
                (bus.mem_req | bus.io_rd_req | bus.io_wr_req) & ~busy, 0);
            if (bus.io_rd_req === 1'b1) io_rd_cycles++;
            if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
                if (q_mem.size() == 0) fail_now("mem_unexpected");
                else chk("mem_addr", bus.mem_addr, q_mem.pop_front());
            end
            if ((bus.io_rd_req | bus.io_wr_req) === 1'b1
                && bus.io_ack === 1'b1) begin
                last_io_addr = bus.io_addr;
                last_io_wdata = bus.io_wdata;
                if (q_io.size() == 0) fail_now("io_unexpected");
                else begin
                    io = q_io.pop_front();
                    chk("io_addr", bus.io_addr, io.addr);
                    chk("io_dir", {bus.io_wr_req, bus.io_rd_req},
                        io.wr ? 2'b10 : 2'b01);
                    if (io.wr) chk("io_wdata", bus.io_wdata, io.wdata);
                end
            end
            if (pc_load === 1'b1) begin
                pc_loads++;
                if (q_cm.size() == 0) fail_now("pc_load_unexpected");
                else begin
                    cm = q_cm.pop_front();
                    chk("pc_value", pc_value, cm.pc);
                    chk("a_load", a_load, cm.aload);
                    if (cm.aload) chk("a_value", a_value, cm.aval);
                end
            end else begin
                chk("a_load_alone", a_load, 0);
            end
        end
    end

    logic [7:0]  fl_tab [2];
    int          lat;
    logic [15:0] pcv;
    logic        al;
    logic [7:0]  av;
    logic        bz;
    int          loads_before;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h1001] = 8'h34;
        mem[16'h1002] = 8'h12;
        mem[16'h2000] = 8'h78;
        mem[16'h2001] = 8'h56;
        mem[16'h3000] = 8'h7F;
        mem[16'h4000] = 8'h10;
        fl_tab[0] = 8'h00;
        fl_tab[1] = 8'hC5;

        notRESET = 1'b0;
        set_jpnn = 1'b0;
        set_jpcc = 8'h00;
        set_out = 1'b0;
        set_in = 1'b0;
        pc_in = 16'h0;
        a_in = 8'h0;
        flags_in = 8'h0;
        repeat (2) @(negedge CLK);
        chk("rst_ctrl", {bus.mem_req, bus.io_rd_req, bus.io_wr_req,
                         pc_load, a_load, busy, err}, 0);
        chk("rst_data", {bus.mem_addr, bus.io_addr, bus.io_wdata,
                         a_value}, 0);
        chk("rst_pc_value", pc_value, 0);
        @(posedge CLK);
        #1 notRESET = 1'b1;

        // JP nn, zero-wait
        issue(0, 0, 16'h1001, 8'h00, 8'h00, bz);
        wait_pc_load(40, lat, pcv, al, av);
        chk("jpnn_latency", lat, 3);
        chk("jpnn_pc", pcv, 16'h1234);

        // JP Z issued in the cycle busy falls; Z clear then Z set
        issue(1, CC_Z, 16'h2000, 8'h00, 8'h00, bz);
        chk("accept_busy_fall", bz, 0);
        wait_pc_load(40, lat, pcv, al, av);
        chk("jpz_not_taken_pc", pcv, 16'h2002);
        issue(1, CC_Z, 16'h2000, 8'h00, 8'h40, bz);
        wait_pc_load(40, lat, pcv, al, av);
        chk("jpz_taken_pc", pcv, 16'h5678);

        // IN A,(0x7F) with the port ack three cycles late
        io_val = 8'h3C;
        io_dly = 3;
        io_rd_cycles = 0;
        issue(2, 0, 16'h3000, 8'hA5, 8'h00, bz);
        wait_pc_load(40, lat, pcv, al, av);
        chk("in_io_addr", last_io_addr, 16'hA57F);
        chk("in_rd_cycles", io_rd_cycles, 4);
        chk("in_a_load", al, 1);
        chk("in_a_value", av, 8'h3C);
        chk("in_pc", pcv, 16'h3001);
        io_dly = 0;

        // OUT (0x10),A
        issue(3, 0, 16'h4000, 8'h55, 8'h00, bz);
        wait_pc_load(40, lat, pcv, al, av);
        chk("out_io_addr", last_io_addr, 16'h5510);
        chk("out_io_wdata", last_io_wdata, 8'h55);
        chk("out_no_a_load", al, 0);
        chk("out_pc", pcv, 16'h4001);
        chk("out_latency", lat, 3);

        // Two strobes at once in IDLE
        @(posedge CLK);
        #1;
        set_jpnn = 1'b1;
        set_in = 1'b1;
        exp_err_cyc = cyc + 1;
        @(posedge CLK);
        #1;
        set_jpnn = 1'b0;
        set_in = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("multi_idle", {busy, bus.mem_req}, 0);
        end

        // Strobes while busy (single and multi-hot) are dropped silently
        mem_dly = 2;
        issue(0, 0, 16'h6000, 8'h00, 8'h00, bz);
        @(posedge CLK);
        #1;
        chk("busy_during_op", busy, 1);
        set_jpnn = 1'b1;
        set_out = 1'b1;
        pc_in = 16'h7000;
        @(posedge CLK);
        #1;
        set_jpnn = 1'b0;
        set_out = 1'b0;
        wait_pc_load(40, lat, pcv, al, av);
        repeat (4) @(negedge CLK);
        mem_dly = 0;

        // JP NC not taken at the top of memory wraps
        issue(1, CC_NC, 16'hFFFF, 8'h00, 8'h01, bz);
        wait_pc_load(40, lat, pcv, al, av);
        chk("wrap_pc", pcv, 16'h0001);

        // Every condition code against all-clear and S/Z/PV/C-set flags
        for (int cc = 0; cc < 8; cc++) begin
            for (int fi = 0; fi < 2; fi++) begin
                mem_dly = fi;
                issue(1, cc, 16'h8000 + 16'(cc * 16 + fi * 4), 8'h00,
                      fl_tab[fi], bz);
                wait_pc_load(40, lat, pcv, al, av);
            end
        end
        mem_dly = 0;

        // Reset during the high-byte fetch
        mem_dly = 3;
        issue(0, 0, 16'h5000, 8'h00, 8'h00, bz);
        lat = 0;
        for (int n = 0; n < 20 && q_mem.size() != 1; n++) begin
            @(negedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("hi_fetch_req", bus.mem_req, 1);
        resp_en = 1'b0;
        man_mem_ack = 1'b0;
        #1 notRESET = 1'b0;
        #1;
        chk("rst_drop_req", {bus.mem_req, busy}, 0);
        q_mem.delete();
        q_io.delete();
        q_cm.delete();
        loads_before = pc_loads;
        @(posedge CLK);
        #1 notRESET = 1'b1;
        @(posedge CLK);
        #1 man_mem_ack = 1'b1;
        @(posedge CLK);
        #1 man_mem_ack = 1'b0;
        repeat (6) @(negedge CLK);
        chk("late_ack_no_load", pc_loads, loads_before);
        chk("late_ack_idle", {busy, bus.mem_req}, 0);
        resp_en = 1'b1;
        mem_dly = 0;

        // Still operational after the reset
        issue(0, 0, 16'h1001, 8'h00, 8'h00, bz);
        wait_pc_load(40, lat, pcv, al, av);
        chk("post_rst_pc", pcv, 16'h1234);
        repeat (2) @(negedge CLK);

        chk("q_mem_empty", q_mem.size(), 0);
        chk("q_io_empty", q_io.size(), 0);
        chk("q_cm_empty", q_cm.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
